sobol_sng_ctrl: RTL

- Stochastic number generator controller, directly downstream of the 1-D Sobol RNG.
- Accepts one binary operand per transaction over a valid/ready handshake.
- Drives the RNG enable for exactly one full Sobol period (2^INWD steps), converting the operand into a unary bitstream by comparing the RNG value against it.
- Emits the bitstream with downstream backpressure and reports the ones-count at end of stream for self-check.

---
 rtl/sng_pkg.sv | 22 ++
 rtl/sng_len_cnt.sv | 49 ++++
 rtl/sobol_sng_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/sng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sng_pkg
//  Purpose  : Shared width defaults and FSM state type for the Sobol
//             stochastic number generator controller.
//  Revision : 1.0  initial release
// ============================================================================
package sng_pkg;

  // Default operand / RNG width; one stream is 2**SNG_INWD bits long.
  localparam int unsigned SNG_INWD = 8;
  localparam int unsigned SNG_LEN  = 2 ** SNG_INWD;

  // Controller phases: wait for operand, stream bits, one-cycle completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sng_state_t;

endpackage
`default_nettype wire

// File: rtl/sng_len_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sng_len_cnt
//  Purpose  : Enabled INWD+1-bit up-counter with synchronous clear and a
//             terminal flag raised while the count equals 2**INWD - 1.
//  Revision : 1.0  initial release
// ============================================================================
module sng_len_cnt
  import sng_pkg::*;
#(
  parameter int unsigned INWD = SNG_INWD
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [INWD:0] cnt,
  output logic          term
);

  localparam logic [INWD:0] TERM_VAL = (INWD + 1)'((1 << INWD) - 1);

  logic [INWD:0] cnt_d;
  logic [INWD:0] cnt_q;

  // Next count: clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign term = (cnt_q == TERM_VAL);

endmodule
`default_nettype wire

// File: rtl/sobol_sng_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sobol_sng_ctrl
//  Purpose  : Converts one binary operand per transaction into a 2**INWD-bit
//             unary stream by comparing it against a Sobol RNG stepped once
//             per transferred bit; reports the ones-count at end of stream.
//  Revision : 1.0  initial release
// ============================================================================
module sobol_sng_ctrl
  import sng_pkg::*;
#(
  parameter int unsigned INWD = SNG_INWD
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [INWD-1:0] in_data,
  output logic            rng_enable,
  input  logic [INWD-1:0] rng_seq,
  output logic            bit_out,
  output logic            bit_valid,
  input  logic            bit_ready,
  output logic            bit_last,
  output logic            done,
  output logic [INWD:0]   ones_cnt
);

  sng_state_t      state_q, state_d;
  logic [INWD-1:0] op_q, op_d;
  logic [INWD:0]   ones_cnt_q, ones_cnt_d;

  logic [INWD:0]   len_cnt_unused;
  logic [INWD:0]   ones_acc;
  logic            len_term;
  logic            ones_term_unused;
  logic            is_run;
  logic            accept;
  logic            xfer;

  // Handshake and stream outputs, all decoded from the current state.
  always_comb begin
    is_run     = (state_q == RUN);
    in_ready   = (state_q == IDLE);
    accept     = in_ready & in_valid;
    bit_valid  = is_run;
    bit_out    = is_run & (rng_seq < op_q);
    xfer       = bit_valid & bit_ready;
    // The RNG only advances when a bit is consumed, so a stall freezes bit_out.
    rng_enable = xfer;
    bit_last   = is_run & len_term;
    done       = (state_q == DONE);
  end

  // Stream length: cleared on operand acceptance, counts transferred bits.
  sng_len_cnt #(.INWD(INWD)) u_len_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (xfer),
    .cnt  (len_cnt_unused),
    .term (len_term)
  );

  // Ones accumulator: counts transferred 1-bits; never exceeds LEN-1.
  sng_len_cnt #(.INWD(INWD)) u_ones_acc (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (xfer & bit_out),
    .cnt  (ones_acc),
    .term (ones_term_unused)
  );

  // Next-state logic for FSM, latched operand and published ones-count.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ones_cnt_d = ones_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = in_data;
          state_d = RUN;
        end
      end
      RUN: begin
        if (xfer && bit_last) begin
          // Include the final bit, which the accumulator has not yet absorbed.
          ones_cnt_d = ones_acc + {{INWD{1'b0}}, bit_out};
          state_d    = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset; reset abandons any partial stream.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      ones_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ones_cnt_q <= ones_cnt_d;
    end
  end

  assign ones_cnt = ones_cnt_q;

endmodule
`default_nettype wire
